// File: rtl/circuit1_vector_checker_pkg.sv
// Shared types and constants for the circuit_1 vector checker.
// Expected truth table and critical path of the gate netlist.
package circuit1_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   localparam int         NUM_VEC             = 8;
   localparam logic [7:0] CIRCUIT1_EXP_MASK   = 8'hAB;
   localparam int         CIRCUIT1_CRIT_DELAY = 22;

endpackage

// File: rtl/circuit1_vector_checker_if.sv
// Stimulus/response bundle between the checker and the circuit side.
// The slave modport is the checker; the master modport drives start and o_in.
interface circuit1_vector_checker_if;

   logic       start;
   logic       o_in;
   logic       a;
   logic       b;
   logic       c;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] captured;
   logic [7:0] fail_vec;
   logic [3:0] mismatch_cnt;

   modport master (
      output start, o_in,
      input  a, b, c, busy, done, pass,
      input  captured, fail_vec, mismatch_cnt
   );

   modport slave (
      input  start, o_in,
      output a, b, c, busy, done, pass,
      output captured, fail_vec, mismatch_cnt
   );

endinterface

// File: rtl/circuit1_vector_checker_settle_timer.sv
// Loadable down-counter that stops at zero; times the per-vector settle.
module settle_timer #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_val,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   assign o_zero = (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (!o_zero) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/circuit1_vector_checker.sv
// Sweeps all 8 {a,b,c} vectors into circuit_1, samples o after a settle
// delay and compares the observed truth table against the expected one.
module circuit1_vector_checker
   import circuit1_pkg::*;
#(
   parameter int         SETTLE   = 23,
   parameter int         CNT_W    = 5,
   parameter logic [7:0] EXP_MASK = CIRCUIT1_EXP_MASK
) (
   input logic                       clk,
   input logic                       rst,
   circuit1_vector_checker_if.slave  bus
);

   localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(SETTLE);

   state_t     r_state;
   logic [2:0] r_vec;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;
   logic [7:0] r_captured;
   logic [7:0] r_fail_vec;
   logic [3:0] r_mismatch_cnt;

   state_t     w_state_nxt;
   logic [2:0] w_vec_nxt;
   logic       w_busy_nxt;
   logic       w_done_nxt;
   logic       w_pass_nxt;
   logic [7:0] w_captured_nxt;
   logic [7:0] w_fail_vec_nxt;
   logic [3:0] w_mismatch_nxt;
   logic       w_load;
   logic       w_zero;
   logic       w_hit;

   settle_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_val  (LP_LOAD),
      .o_zero (w_zero)
   );

   assign w_hit = (bus.o_in != EXP_MASK[r_vec]);

   always_comb begin
      w_state_nxt    = r_state;
      w_vec_nxt      = r_vec;
      w_busy_nxt     = r_busy;
      w_done_nxt     = r_done;
      w_pass_nxt     = r_pass;
      w_captured_nxt = r_captured;
      w_fail_vec_nxt = r_fail_vec;
      w_mismatch_nxt = r_mismatch_cnt;
      w_load         = 1'b0;
      unique case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_state_nxt    = WAIT;
               w_vec_nxt      = 3'd0;
               w_load         = 1'b1;
               w_busy_nxt     = 1'b1;
               w_done_nxt     = 1'b0;
               w_pass_nxt     = 1'b0;
               w_captured_nxt = 8'd0;
               w_fail_vec_nxt = 8'd0;
               w_mismatch_nxt = 4'd0;
            end
         end
         WAIT: begin
            if (w_zero) begin
               w_captured_nxt[r_vec] = bus.o_in;
               if (w_hit) begin
                  w_fail_vec_nxt[r_vec] = 1'b1;
                  w_mismatch_nxt        = r_mismatch_cnt + 4'd1;
               end
               if (r_vec == 3'd7) begin
                  w_state_nxt = DONE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_pass_nxt  = (r_mismatch_cnt == 4'd0) && !w_hit;
               end else begin
                  w_vec_nxt = r_vec + 3'd1;
                  w_load    = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_vec          <= 3'd0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_pass         <= 1'b0;
         r_captured     <= 8'd0;
         r_fail_vec     <= 8'd0;
         r_mismatch_cnt <= 4'd0;
      end else begin
         r_state        <= w_state_nxt;
         r_vec          <= w_vec_nxt;
         r_busy         <= w_busy_nxt;
         r_done         <= w_done_nxt;
         r_pass         <= w_pass_nxt;
         r_captured     <= w_captured_nxt;
         r_fail_vec     <= w_fail_vec_nxt;
         r_mismatch_cnt <= w_mismatch_nxt;
      end
   end

   assign bus.a            = r_vec[2];
   assign bus.b            = r_vec[1];
   assign bus.c            = r_vec[0];
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.pass         = r_pass;
   assign bus.captured     = r_captured;
   assign bus.fail_vec     = r_fail_vec;
   assign bus.mismatch_cnt = r_mismatch_cnt;

endmodule

// File: tb/tb_circuit1_vector_checker.sv
// Bench for circuit1_vector_checker: three instances (SETTLE 23, 2, 0)
// driven by a delayed circuit_1 model, a tied-0 output and an inverted model.
module tb_circuit1_vector_checker;

   typedef struct packed {
      logic [7:0] cap;
      logic [7:0] fv;
      logic [3:0] mc;
      logic       pass;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mode_inv = 1'b0;
   int   checks = 0;
   int   failures = 0;
   res_t sb[$];

   logic [21:0] dla = '0;
   logic [21:0] dlc = '0;

   always #5 clk = ~clk;

   circuit1_vector_checker_if ifa ();
   circuit1_vector_checker_if ifb ();
   circuit1_vector_checker_if ifc ();

   circuit1_vector_checker #(.SETTLE(23)) ua (
      .clk (clk), .rst (rst), .bus (ifa));
   circuit1_vector_checker #(.SETTLE(2)) ub (
      .clk (clk), .rst (rst), .bus (ifb));
   circuit1_vector_checker #(.SETTLE(0)) uc (
      .clk (clk), .rst (rst), .bus (ifc));

   function automatic logic ideal(logic a, logic b, logic c);
      return ~(a | b) | c;
   endfunction

   // 22-cycle transport delay stands in for the gate-level critical path
   always @(posedge clk) begin
      dla <= {dla[20:0], ideal(ifa.a, ifa.b, ifa.c)};
      dlc <= {dlc[20:0], ideal(ifc.a, ifc.b, ifc.c)};
   end

   assign ifa.o_in = mode_inv ? ~ideal(ifa.a, ifa.b, ifa.c) : dla[21];
   assign ifb.o_in = 1'b0;
   assign ifc.o_in = dlc[21];

   function automatic res_t model(int kind);
      res_t r;
      logic [2:0] v;
      logic want, obs;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         v = i[2:0];
         want = ideal(v[2], v[1], v[0]);
         obs = (kind == 0) ? want : (kind == 1) ? 1'b0 : ~want;
         r.cap[i] = obs;
         if (obs != want) begin
            r.fv[i] = 1'b1;
            r.mc = r.mc + 4'd1;
         end
      end
      r.pass = (r.mc == 4'd0);
      return r;
   endfunction

   function automatic res_t snap(int w);
      res_t r;
      case (w)
         0: r = '{ifa.captured, ifa.fail_vec, ifa.mismatch_cnt, ifa.pass};
         1: r = '{ifb.captured, ifb.fail_vec, ifb.mismatch_cnt, ifb.pass};
         default: r = '{ifc.captured, ifc.fail_vec, ifc.mismatch_cnt, ifc.pass};
      endcase
      return r;
   endfunction

   // {busy, done, a, b, c}
   function automatic logic [4:0] st(int w);
      case (w)
         0: return {ifa.busy, ifa.done, ifa.a, ifa.b, ifa.c};
         1: return {ifb.busy, ifb.done, ifb.a, ifb.b, ifb.c};
         default: return {ifc.busy, ifc.done, ifc.a, ifc.b, ifc.c};
      endcase
   endfunction

   task automatic drive_start(int w, logic v);
      case (w)
         0: ifa.start = v;
         1: ifb.start = v;
         default: ifc.start = v;
      endcase
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start, optionally re-pulse it while vector rv is applied, and
   // measure cycles from the start edge to done.
   task automatic sweep(int w, int lat, int rv, string tag);
      int n;
      logic pulsed;
      logic [4:0] s;
      drive_start(w, 1'b1);
      tick();
      drive_start(w, 1'b0);
      s = st(w);
      chk({tag, "_busy_at_start"}, {30'd0, s[4:3]}, 32'd2);
      n = 0;
      pulsed = 1'b0;
      while (!st(w)[3] && n < lat + 4) begin
         tick();
         drive_start(w, 1'b0);
         n++;
         if (rv >= 0 && !pulsed && st(w)[2:0] == rv[2:0]) begin
            drive_start(w, 1'b1);
            pulsed = 1'b1;
         end
      end
      drive_start(w, 1'b0);
      chk({tag, "_latency"}, n, lat);
      if (rv >= 0) chk({tag, "_repulse_seen"}, {31'd0, pulsed}, 32'd1);
   endtask

   task automatic score(int w, string tag);
      res_t e, o;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         o = snap(w);
         chk({tag, "_captured"}, {24'd0, o.cap}, {24'd0, e.cap});
         chk({tag, "_fail_vec"}, {24'd0, o.fv}, {24'd0, e.fv});
         chk({tag, "_mismatch"}, {28'd0, o.mc}, {28'd0, e.mc});
         chk({tag, "_pass"}, {31'd0, o.pass}, {31'd0, e.pass});
         chk({tag, "_busy_done"}, {30'd0, st(w)[4:3]}, 32'd1);
      end
   endtask

   initial begin
      int n;
      res_t o;
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      ifc.start = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      o = snap(0);
      chk("rst_outputs", {o, st(0)}, '0);
      o = snap(1);
      chk("rst_outputs_b", {o, st(1)}, '0);
      rst = 1'b0;
      repeat (30) tick();

      sb.push_back(model(0));
      sweep(0, 192, -1, "good23");
      score(0, "good23");

      sb.push_back(model(1));
      sweep(1, 24, -1, "zero2");
      score(1, "zero2");

      sweep(2, 8, -1, "settle0");
      o = snap(2);
      chk("settle0_fail_any", {31'd0, (o.fv != 8'd0)}, 32'd1);
      chk("settle0_pass", {31'd0, o.pass}, 32'd0);

      mode_inv = 1'b1;
      sb.push_back(model(2));
      sweep(0, 192, -1, "inv23");
      score(0, "inv23");

      drive_start(0, 1'b1);
      tick();
      drive_start(0, 1'b0);
      o = snap(0);
      chk("restart_results", {12'd0, o}, '0);
      chk("restart_busy_done", {30'd0, st(0)[4:3]}, 32'd2);
      mode_inv = 1'b0;

      n = 0;
      while (st(0)[2:0] != 3'd5 && n < 300) begin
         tick();
         n++;
      end
      chk("reach_vec5", {29'd0, st(0)[2:0]}, 32'd5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      o = snap(0);
      chk("midsweep_rst", {o, st(0)}, '0);
      tick();
      chk("post_rst_idle", {o, st(0)}, '0);

      sb.push_back(model(0));
      sweep(0, 192, 3, "repulse");
      score(0, "repulse");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/circuit1_vector_checker.md
Name: circuit1_vector_checker

Overview:
- Sequential stimulus/response stage wrapped around the circuit_1 gate netlist (o = ~(a|b) when c=0, o = 1 when c=1).
- Drives the netlist's a, b and c inputs through all 8 input combinations.
- Waits a programmable settle time per vector, long enough to cover the 22-unit critical path (nand 4 + xor 2 + and 7 + nor 6 + or 3).
- Samples o, builds the observed truth table and compares it against the expected one. Used as the self-check harness for gate-delay simulation runs.

Parameters:
- SETTLE, 23: cycles to hold each vector before sampling (0 allowed = sample on the next edge).
- CNT_W, 5: width of the settle counter; must satisfy SETTLE < 2**CNT_W.
- EXP_MASK, 8'hAB: expected o per vector index {a,b,c}; bit i = expected o for vector i.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE or DONE
- o_in  in  1  output o of the circuit under test
- a  out  1  drive to circuit input a = vec[2]
- b  out  1  drive to circuit input b = vec[1]
- c  out  1  drive to circuit input c = vec[0]
- busy  out  1  sweep in progress
- done  out  1  sweep complete; results valid
- pass  out  1  done and zero mismatches
- captured  out  8  observed o per vector index
- fail_vec  out  8  bit i set if vector i mismatched
- mismatch_cnt  out  4  number of mismatching vectors, 0..8

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst.
- Reset behaviour: on any edge with rst=1, state=IDLE, vec=0 (a=b=c=0), cnt=0, busy=done=pass=0, captured=fail_vec=0, mismatch_cnt=0. rst has priority over every other input, including mid-sweep; a sweep aborted by reset leaves no partial results.
- All outputs are registered; a/b/c come straight from the vec register.
- FSM states: IDLE, WAIT, DONE.
- IDLE, start=1 at edge k:
  - vec<=0, cnt<=SETTLE, captured/fail_vec/mismatch_cnt cleared, busy<=1, state<=WAIT.
- WAIT, cnt!=0: cnt<=cnt-1.
- WAIT, cnt==0 (sample edge):
  - captured[vec]<=o_in.
  - If o_in != EXP_MASK[vec]: fail_vec[vec]<=1 and mismatch_cnt<=mismatch_cnt+1.
  - If vec==7: state<=DONE, busy<=0, done<=1, pass<=(no mismatch including this sample).
  - Else: vec<=vec+1, cnt<=SETTLE.
- Timing: each vector is held exactly SETTLE+1 cycles. Vector i is sampled at edge k+(i+1)(SETTLE+1). done rises after edge k+8(SETTLE+1).
- DONE:
  - Outputs hold; vec stays 7.
  - start=1 restarts exactly as from IDLE: results cleared, done<=0, pass<=0, busy<=1.
- start while in WAIT is ignored.
- mismatch_cnt never exceeds 8 and never wraps.
- pass is only ever 1 while done is 1.

Decomposition:
- Package circuit1_pkg holds:
  - state enum {IDLE, WAIT, DONE}
  - NUM_VEC=8
  - CIRCUIT1_EXP_MASK=8'hAB
  - CIRCUIT1_CRIT_DELAY=22
- One sub-module, settle_timer: a CNT_W-bit loadable down-counter with load and zero outputs, instantiated once.

Test Plan:
- Good circuit_1 model (gate delays, 1 unit = 1 cycle), SETTLE=23, start pulse -> done after 192 cycles, captured=8'hAB, fail_vec=0, mismatch_cnt=0, pass=1.
- o_in tied 0, SETTLE=2 -> done exactly 24 cycles after the start edge, captured=0, fail_vec=8'hAB, mismatch_cnt=5, pass=0.
- Good model, SETTLE=0 (sampling before paths settle) -> at least one fail_vec bit set, pass=0.
- start re-pulsed during WAIT at vector 3 -> ignored, sweep completes on its original schedule; start in DONE -> results clear on the next edge, busy=1, done=0.
- rst asserted at vector 5 -> next edge all outputs 0, state IDLE; a following start gives a clean full sweep with pass=1 on the good model.
- o_in = ~expected (inverted model) -> fail_vec=8'hFF, mismatch_cnt=8 (no wrap), pass=0.
